// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-subset datapath and its controller.
// Latency: none (constants, types and pure functions only).
// Backpressure: n/a.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  // Datapath mux / ALU select encodings
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] MR_ALU = 2'b00, MR_MDR = 2'b01, MR_PC = 2'b10;
  localparam logic [1:0] SB_B = 2'b00, SB_4 = 2'b01, SB_IMM = 2'b10, SB_BROFF = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010,
                         ALU_OR = 3'b011, ALU_LUI = 3'b100;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_A = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       branch_eq;
    logic       branch_ne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctrl_t;

  // R-type functions the datapath implements (jr included)
  function automatic logic rtype_known(logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR) ||
           (fn == FN_SLT) || (fn == FN_SLTU) || (fn == FN_JR);
  endfunction

  // Whole-instruction legality as seen in DECODE
  function automatic logic instr_known(logic [5:0] op, logic [5:0] fn);
    case (op)
      OP_RTYPE:                        return rtype_known(fn);
      OP_LW, OP_SW, OP_ADDI, OP_ORI,
      OP_LUI, OP_BEQ, OP_BNE, OP_J,
      OP_JAL:                          return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state(+opcode, mem_ready) to control-vector decoder.
// Latency: 0 cycles; pure decode, all-zero while reset is low.
// Backpressure: FETCH write strobes are gated by mem_ready; other states ignore it.
import mips_pkg::*;

module mc_out_decode #(
  parameter int OPW = 6
) (
  input  logic           reset,
  input  state_t         st,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           mem_ready,
  output ctrl_t          ctrl
);

  // Moore decode of the current state; reset low silences every strobe
  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (st)
        S_FETCH: begin
          ctrl.memread = 1'b1;
          ctrl.alusrcb = SB_4;
          ctrl.irwrite = mem_ready;
          ctrl.pcwrite = mem_ready;
        end
        S_DECODE: begin
          ctrl.alusrcb = SB_BROFF;
          ctrl.illegal = !instr_known(opcode, funct);
        end
        S_MEMADR: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SB_IMM;
        end
        S_MEMRD: begin
          ctrl.iord    = 1'b1;
          ctrl.memread = 1'b1;
        end
        S_MEMWB: begin
          ctrl.regwrite = 1'b1;
          ctrl.memtoreg = MR_MDR;
        end
        S_MEMWR: begin
          ctrl.iord     = 1'b1;
          ctrl.memwrite = 1'b1;
        end
        S_EXEC: begin
          ctrl.alusrca = 1'b1;
          ctrl.aluop   = ALU_FUNCT;
        end
        S_ALUWB: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = RD_RD;
        end
        S_IMMEX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SB_IMM;
          if (opcode == OP_ORI) begin
            ctrl.aluop   = ALU_OR;
            ctrl.zeroext = 1'b1;
          end else if (opcode == OP_LUI) begin
            ctrl.aluop = ALU_LUI;
          end
        end
        S_IMMWB: ctrl.regwrite = 1'b1;
        S_BRANCH: begin
          ctrl.alusrca   = 1'b1;
          ctrl.aluop     = ALU_SUB;
          ctrl.pcsrc     = PC_ALUOUT;
          ctrl.branch_eq = (opcode == OP_BEQ);
          ctrl.branch_ne = (opcode == OP_BNE);
        end
        S_JUMP: begin
          ctrl.pcwrite = 1'b1;
          ctrl.pcsrc   = PC_JUMP;
        end
        S_JAL: begin
          ctrl.pcwrite  = 1'b1;
          ctrl.pcsrc    = PC_JUMP;
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = RD_RA;
          ctrl.memtoreg = MR_PC;
        end
        S_JR: begin
          ctrl.pcwrite = 1'b1;
          ctrl.pcsrc   = PC_A;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: state register plus next-state logic.
// Latency: lw 5, sw/R/imm 4, branch/jump 3, illegal 2 cycles with memory always ready.
// Backpressure: FETCH, MEMRD and MEMWR hold with stable strobes while mem_ready is low.
import mips_pkg::*;

module multicycle_controller #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           mem_ready,
  output logic           pcwrite,
  output logic           branch_eq,
  output logic           branch_ne,
  output logic           iord,
  output logic           memread,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic [1:0]     regdst,
  output logic [1:0]     memtoreg,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic           zeroext,
  output logic [2:0]     aluop,
  output logic [1:0]     pcsrc,
  output logic           illegal,
  output logic [3:0]     state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // Sequencing: where the current step hands over next
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:           state_d = S_MEMADR;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMMEX;
          OP_BEQ, OP_BNE:         state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          OP_JAL:                 state_d = S_JAL;
          OP_RTYPE: begin
            if (funct == FN_JR)          state_d = S_JR;
            else if (rtype_known(funct)) state_d = S_EXEC;
            else                         state_d = S_FETCH;
          end
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset low restarts at FETCH, abandoning any instruction
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mc_out_decode #(.OPW(OPW)) u_dec (
    .reset     (reset),
    .st        (state_q),
    .opcode    (opcode),
    .funct     (funct),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pcwrite   = ctrl.pcwrite;
  assign branch_eq = ctrl.branch_eq;
  assign branch_ne = ctrl.branch_ne;
  assign iord      = ctrl.iord;
  assign memread   = ctrl.memread;
  assign memwrite  = ctrl.memwrite;
  assign irwrite   = ctrl.irwrite;
  assign regwrite  = ctrl.regwrite;
  assign regdst    = ctrl.regdst;
  assign memtoreg  = ctrl.memtoreg;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign zeroext   = ctrl.zeroext;
  assign aluop     = ctrl.aluop;
  assign pcsrc     = ctrl.pcsrc;
  assign illegal   = ctrl.illegal;
  // While reset is low the debug view reads FETCH regardless of the register
  assign state     = reset ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller with a per-instruction trace model.
// Latency: n/a.
// Backpressure: mem_ready stalls are injected in FETCH and memory steps.
import mips_pkg::*;

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pcwrite, branch_eq, branch_ne, iord, memread, memwrite, irwrite, regwrite;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic       alusrca, zeroext, illegal;
  logic [2:0] aluop;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwrite, branch_eq, branch_ne, iord, memread, memwrite, irwrite, regwrite;
    logic [1:0] regdst, memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
  } vec_t;

  vec_t exp_q[$];
  bit   rdy_q[$];
  vec_t obs_q[$];

  multicycle_controller #(.OPW(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch_eq(branch_eq), .branch_ne(branch_ne), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .zeroext(zeroext), .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t sample();
    vec_t v;
    v.st = state; v.pcwrite = pcwrite; v.branch_eq = branch_eq; v.branch_ne = branch_ne;
    v.iord = iord; v.memread = memread; v.memwrite = memwrite; v.irwrite = irwrite;
    v.regwrite = regwrite; v.regdst = regdst; v.memtoreg = memtoreg; v.alusrca = alusrca;
    v.alusrcb = alusrcb; v.zeroext = zeroext; v.aluop = aluop; v.pcsrc = pcsrc;
    v.illegal = illegal;
    return v;
  endfunction

  function automatic bit model_legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b100011, 6'b101011, 6'b001000, 6'b001101, 6'b001111,
      6'b000100, 6'b000101, 6'b000010, 6'b000011: return 1'b1;
      6'b000000: return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                   6'b101010, 6'b101011, 6'b001000};
      default:   return 1'b0;
    endcase
  endfunction

  function automatic void add(vec_t v, bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endfunction

  // Expected cycle-by-cycle trace of one instruction, fst/mst = stall cycles
  function automatic void build_trace(logic [5:0] op, logic [5:0] fn, int fst, int mst);
    vec_t v;
    exp_q.delete(); rdy_q.delete();
    v = '0; v.st = S_FETCH; v.memread = 1; v.alusrcb = 2'b01;
    for (int i = 0; i < fst; i++) add(v, 1'b0);
    v.irwrite = 1; v.pcwrite = 1; add(v, 1'b1);
    v = '0; v.st = S_DECODE; v.alusrcb = 2'b11;
    v.illegal = !model_legal(op, fn);
    add(v, 1'($urandom));
    if (v.illegal) return;
    v = '0;
    case (op)
      6'b100011, 6'b101011: begin
        v.st = S_MEMADR; v.alusrca = 1; v.alusrcb = 2'b10; add(v, 1'($urandom));
        v = '0; v.iord = 1;
        if (op == 6'b100011) begin v.st = S_MEMRD; v.memread = 1; end
        else begin v.st = S_MEMWR; v.memwrite = 1; end
        for (int i = 0; i < mst; i++) add(v, 1'b0);
        add(v, 1'b1);
        if (op == 6'b100011) begin
          v = '0; v.st = S_MEMWB; v.regwrite = 1; v.memtoreg = 2'b01; add(v, 1'($urandom));
        end
      end
      6'b000000: begin
        if (fn == 6'b001000) begin
          v.st = S_JR; v.pcwrite = 1; v.pcsrc = 2'b11; add(v, 1'($urandom));
        end else begin
          v.st = S_EXEC; v.alusrca = 1; v.aluop = 3'b010; add(v, 1'($urandom));
          v = '0; v.st = S_ALUWB; v.regwrite = 1; v.regdst = 2'b01; add(v, 1'($urandom));
        end
      end
      6'b001000, 6'b001101, 6'b001111: begin
        v.st = S_IMMEX; v.alusrca = 1; v.alusrcb = 2'b10;
        if (op == 6'b001101) begin v.aluop = 3'b011; v.zeroext = 1; end
        if (op == 6'b001111) v.aluop = 3'b100;
        add(v, 1'($urandom));
        v = '0; v.st = S_IMMWB; v.regwrite = 1; add(v, 1'($urandom));
      end
      6'b000100, 6'b000101: begin
        v.st = S_BRANCH; v.alusrca = 1; v.aluop = 3'b001; v.pcsrc = 2'b01;
        v.branch_eq = (op == 6'b000100); v.branch_ne = (op == 6'b000101);
        add(v, 1'($urandom));
      end
      6'b000010: begin
        v.st = S_JUMP; v.pcwrite = 1; v.pcsrc = 2'b10; add(v, 1'($urandom));
      end
      default: begin
        v.st = S_JAL; v.pcwrite = 1; v.pcsrc = 2'b10; v.regwrite = 1;
        v.regdst = 2'b10; v.memtoreg = 2'b10; add(v, 1'($urandom));
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one built trace and records what the DUT showed each cycle
  task automatic run_trace(input logic [5:0] op, input logic [5:0] fn);
    obs_q.delete();
    opcode = op; funct = fn;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      @(negedge clk);
      obs_q.push_back(sample());
      tick();
    end
  endtask

  task automatic test_reset();
    vec_t z;
    z = '0; z.st = S_FETCH;
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sample() !== z) begin
        errors++; $display("FAIL reset_init cyc%0d got %h exp %h", i, sample(), z);
      end
      tick();
    end
    reset = 1'b1;
  endtask

  task automatic test_lw();
    build_trace(6'b100011, 6'h00, 0, 0);
    run_trace(6'b100011, 6'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL lw cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() != 5 || obs_q[4].regwrite !== 1'b1 || obs_q[3].regwrite !== 1'b0) begin
      errors++; $display("FAIL lw_wb len %0d rw_last %b", obs_q.size(), obs_q[obs_q.size()-1].regwrite);
    end
  endtask

  task automatic test_sw_stall();
    int n;
    build_trace(6'b101011, 6'h00, 0, 3);
    run_trace(6'b101011, 6'h00);
    n = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sw_stall cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].memwrite === 1'b1 && obs_q[i].iord === 1'b1) n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL sw_write_cycles got %0d exp 4", n); end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'(S_FETCH)) begin
      errors++; $display("FAIL sw_return got %0d exp %0d", state, S_FETCH);
    end
    tick();
  endtask

  task automatic test_branches();
    logic [5:0] ops [2];
    ops[0] = 6'b000100; ops[1] = 6'b000101;
    for (int k = 0; k < 2; k++) begin
      build_trace(ops[k], 6'h00, 0, 0);
      run_trace(ops[k], 6'h00);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL branch%0d cyc%0d got %h exp %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_q.size() != 3 || obs_q[2].branch_eq !== (k == 0) || obs_q[2].branch_ne !== (k == 1)) begin
        errors++; $display("FAIL branch%0d_flags eq %b ne %b", k, obs_q[2].branch_eq, obs_q[2].branch_ne);
      end
    end
  endtask

  task automatic test_jumps();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops[0] = 6'b000011; fns[0] = 6'h00;
    ops[1] = 6'b000000; fns[1] = 6'b001000;
    ops[2] = 6'b000010; fns[2] = 6'h15;
    for (int k = 0; k < 3; k++) begin
      build_trace(ops[k], fns[k], 0, 0);
      run_trace(ops[k], fns[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL jump%0d cyc%0d got %h exp %h", k, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2];
    logic [5:0] fns [2];
    ops[0] = 6'b111111; fns[0] = 6'h20;
    ops[1] = 6'b000000; fns[1] = 6'b111111;
    for (int k = 0; k < 2; k++) begin
      build_trace(ops[k], fns[k], 1, 0);
      run_trace(ops[k], fns[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL illegal%0d cyc%0d got %h exp %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_q.size() != 3 || obs_q[2].illegal !== 1'b1 || obs_q[2].regwrite !== 1'b0 ||
          obs_q[2].memwrite !== 1'b0 || obs_q[2].pcwrite !== 1'b0) begin
        errors++; $display("FAIL illegal%0d_pulse len %0d ill %b", k, obs_q.size(), obs_q[obs_q.size()-1].illegal);
      end
    end
  endtask

  task automatic test_reset_mid_lw();
    vec_t z;
    z = '0; z.st = S_FETCH;
    opcode = 6'b100011; funct = 6'h00; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'(S_MEMRD) || memread !== 1'b1 || iord !== 1'b1) begin
      errors++; $display("FAIL rst_pre state %0d rd %b iord %b exp %0d 1 1", state, memread, iord, S_MEMRD);
    end
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sample() !== z) begin
        errors++; $display("FAIL rst_mid cyc%0d got %h exp %h", i, sample(), z);
      end
      tick();
    end
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (memread !== 1'b1 || iord !== 1'b0 || regwrite !== 1'b0 || state !== 4'(S_FETCH)) begin
      errors++; $display("FAIL rst_release rd %b iord %b rw %b st %0d exp 1 0 0 %0d",
                         memread, iord, regwrite, state, S_FETCH);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic [5:0] pool [11];
    pool = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001101, 6'b001111,
             6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b000000};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0:       fn = 6'($urandom);
        1:       fn = 6'b001000;
        default: fn = 6'b100000 | 6'($urandom_range(0, 11));
      endcase
      build_trace(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      run_trace(op, fn);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d op %b fn %b cyc%0d got %h exp %h",
                             n, op, fn, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_branches();
    test_jumps();
    test_illegal();
    test_reset_mid_lw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
